// File: rtl/handin_judge_pkg.sv
// Shared constants for the hand-in judge: state encoding, round result codes
// and default sizes.
package judge_pkg;

    localparam int NUM_CARDS_DEF = 9;
    localparam int CODE_W_DEF    = 4;

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] JUDGE   = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [1:0] RES_TIE = 2'b00;
    localparam logic [1:0] RES_P1  = 2'b01;
    localparam logic [1:0] RES_P2  = 2'b10;

endpackage

// File: rtl/handin_judge_code_decoder.sv
// Encoded card code to one-hot; codes at or above NUM_CARDS decode to all-zero.
module code_decoder
    import judge_pkg::*;
#(
    parameter int NUM_CARDS = NUM_CARDS_DEF,
    parameter int CODE_W    = CODE_W_DEF
) (
    input  logic [CODE_W-1:0]    code,
    output logic [NUM_CARDS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_CARDS; i++) begin
            if (code == CODE_W'(i)) onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/handin_judge.sv
// Card hand-in judge: collects one legal card per player, judges the round,
// keeps scores and used-card masks. Optional LAST_CARD_OUT_EN adds p1_last/p2_last.
module handin_judge
    import judge_pkg::*;
#(
    parameter int NUM_CARDS = NUM_CARDS_DEF,
    parameter int CODE_W    = CODE_W_DEF,
    parameter int SCORE_W   = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 p1_valid,
    input  logic [CODE_W-1:0]    p1_code,
    output logic                 p1_ready,
    input  logic                 p2_valid,
    input  logic [CODE_W-1:0]    p2_code,
    output logic                 p2_ready,
    output logic [NUM_CARDS-1:0] p1_used,
    output logic [NUM_CARDS-1:0] p2_used,
    output logic [SCORE_W-1:0]   p1_score,
    output logic [SCORE_W-1:0]   p2_score,
    output logic [CODE_W-1:0]    round_cnt,
    output logic                 result_valid,
    output logic [1:0]           result,
    output logic [1:0]           illegal,
    output logic                 game_over
`ifdef LAST_CARD_OUT_EN
    ,
    output logic [NUM_CARDS-1:0] p1_last,
    output logic [NUM_CARDS-1:0] p2_last
`endif
);

    logic [1:0]           state_q, state_d;
    logic [CODE_W-1:0]    slot1_q, slot1_d, slot2_q, slot2_d;
    logic                 full1_q, full1_d, full2_q, full2_d;
    logic [NUM_CARDS-1:0] used1_q, used1_d, used2_q, used2_d;
    logic [SCORE_W-1:0]   score1_q, score1_d, score2_q, score2_d;
    logic [CODE_W-1:0]    round_q, round_d;
    logic                 result_valid_q, result_valid_d;
    logic [1:0]           result_q, result_d;
    logic [1:0]           illegal_q, illegal_d;
    logic                 game_over_q, game_over_d;
`ifdef LAST_CARD_OUT_EN
    logic [NUM_CARDS-1:0] last1_q, last1_d, last2_q, last2_d;
`endif

    logic [CODE_W-1:0]    dec_in1, dec_in2;
    logic [NUM_CARDS-1:0] dec1, dec2;
    logic                 legal1, legal2, hs1, hs2;

    // One decoder per player: it sees the offered code while collecting and
    // the latched slot while judging, so it serves legality and mask update.
    always_comb begin
        dec_in1 = (state_q == JUDGE) ? slot1_q : p1_code;
        dec_in2 = (state_q == JUDGE) ? slot2_q : p2_code;
    end

    code_decoder #(.NUM_CARDS(NUM_CARDS), .CODE_W(CODE_W)) u_dec1 (
        .code   (dec_in1),
        .onehot (dec1)
    );

    code_decoder #(.NUM_CARDS(NUM_CARDS), .CODE_W(CODE_W)) u_dec2 (
        .code   (dec_in2),
        .onehot (dec2)
    );

    always_comb begin
        p1_ready = (state_q == COLLECT) && !full1_q;
        p2_ready = (state_q == COLLECT) && !full2_q;
        hs1      = p1_valid && p1_ready;
        hs2      = p2_valid && p2_ready;
        legal1   = (|dec1) && !(|(dec1 & used1_q));
        legal2   = (|dec2) && !(|(dec2 & used2_q));
    end

    always_comb begin
        state_d        = state_q;
        slot1_d        = slot1_q;
        slot2_d        = slot2_q;
        full1_d        = full1_q;
        full2_d        = full2_q;
        used1_d        = used1_q;
        used2_d        = used2_q;
        score1_d       = score1_q;
        score2_d       = score2_q;
        round_d        = round_q;
        result_valid_d = 1'b0;
        result_d       = result_q;
        illegal_d      = 2'b00;
        game_over_d    = game_over_q;
`ifdef LAST_CARD_OUT_EN
        last1_d        = last1_q;
        last2_d        = last2_q;
`endif
        case (state_q)
            COLLECT: begin
                if (hs1 && legal1) begin
                    slot1_d = p1_code;
                    full1_d = 1'b1;
                end
                if (hs2 && legal2) begin
                    slot2_d = p2_code;
                    full2_d = 1'b1;
                end
                illegal_d = {hs2 && !legal2, hs1 && !legal1};
                if (full1_d && full2_d) state_d = JUDGE;
            end
            JUDGE: begin
                used1_d        = used1_q | dec1;
                used2_d        = used2_q | dec2;
                slot1_d        = '0;
                slot2_d        = '0;
                full1_d        = 1'b0;
                full2_d        = 1'b0;
                round_d        = round_q + CODE_W'(1);
                result_valid_d = 1'b1;
`ifdef LAST_CARD_OUT_EN
                last1_d        = dec1;
                last2_d        = dec2;
`endif
                if (slot1_q > slot2_q) begin
                    result_d = RES_P1;
                    score1_d = score1_q + SCORE_W'(1);
                end else if (slot2_q > slot1_q) begin
                    result_d = RES_P2;
                    score2_d = score2_q + SCORE_W'(1);
                end else begin
                    result_d = RES_TIE;
                end
                if (round_q == CODE_W'(NUM_CARDS - 1)) begin
                    state_d     = DONE;
                    game_over_d = 1'b1;
                end else begin
                    state_d = COLLECT;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= COLLECT;
            slot1_q        <= '0;
            slot2_q        <= '0;
            full1_q        <= 1'b0;
            full2_q        <= 1'b0;
            used1_q        <= '0;
            used2_q        <= '0;
            score1_q       <= '0;
            score2_q       <= '0;
            round_q        <= '0;
            result_valid_q <= 1'b0;
            result_q       <= RES_TIE;
            illegal_q      <= 2'b00;
            game_over_q    <= 1'b0;
`ifdef LAST_CARD_OUT_EN
            last1_q        <= '0;
            last2_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            slot1_q        <= slot1_d;
            slot2_q        <= slot2_d;
            full1_q        <= full1_d;
            full2_q        <= full2_d;
            used1_q        <= used1_d;
            used2_q        <= used2_d;
            score1_q       <= score1_d;
            score2_q       <= score2_d;
            round_q        <= round_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            illegal_q      <= illegal_d;
            game_over_q    <= game_over_d;
`ifdef LAST_CARD_OUT_EN
            last1_q        <= last1_d;
            last2_q        <= last2_d;
`endif
        end
    end

    assign p1_used      = used1_q;
    assign p2_used      = used2_q;
    assign p1_score     = score1_q;
    assign p2_score     = score2_q;
    assign round_cnt    = round_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign illegal      = illegal_q;
    assign game_over    = game_over_q;
`ifdef LAST_CARD_OUT_EN
    assign p1_last      = last1_q;
    assign p2_last      = last2_q;
`endif

endmodule

// File: tb/tb_handin_judge.sv
// Randomized self-checking bench for handin_judge against a round-level model.
// Builds with or without LAST_CARD_OUT_EN.
module tb_handin_judge;

    localparam int NC = 9;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       p1_valid = 1'b0, p2_valid = 1'b0;
    logic [3:0] p1_code = '0, p2_code = '0;
    logic       p1_ready, p2_ready;
    logic [8:0] p1_used, p2_used;
    logic [3:0] p1_score, p2_score, round_cnt;
    logic       result_valid, game_over;
    logic [1:0] result, illegal;
`ifdef LAST_CARD_OUT_EN
    logic [8:0] p1_last, p2_last;
`endif

    handin_judge dut (
        .clk(clk), .resetn(resetn),
        .p1_valid(p1_valid), .p1_code(p1_code), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_code(p2_code), .p2_ready(p2_ready),
        .p1_used(p1_used), .p2_used(p2_used),
        .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt),
        .result_valid(result_valid), .result(result),
        .illegal(illegal), .game_over(game_over)
`ifdef LAST_CARD_OUT_EN
        , .p1_last(p1_last), .p2_last(p2_last)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: which cards each player has spent, scores, rounds judged.
    bit m_used1 [NC];
    bit m_used2 [NC];
    int m_s1, m_s2, m_round;

    function automatic logic [8:0] mask_of(input bit u [NC]);
        logic [8:0] m;
        m = '0;
        for (int i = 0; i < NC; i++) if (u[i]) m[i] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        step();
        resetn = 1'b0;
        #3;
        resetn = 1'b1;
        step();
        for (int i = 0; i < NC; i++) begin
            m_used1[i] = 1'b0;
            m_used2[i] = 1'b0;
        end
        m_s1 = 0;
        m_s2 = 0;
        m_round = 0;
    endtask

    // Offers one card from one player and checks the illegal pulse against the model.
    task automatic offer_illegal(input int who, input int code);
        bit exp_ill;
        logic [1:0] exp_vec;
        if (who == 1) exp_ill = (code >= NC) || m_used1[code];
        else          exp_ill = (code >= NC) || m_used2[code];
        exp_vec = (who == 1) ? {1'b0, exp_ill} : {exp_ill, 1'b0};
        if (who == 1) begin p1_valid = 1'b1; p1_code = 4'(code); end
        else          begin p2_valid = 1'b1; p2_code = 4'(code); end
        step();
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        total++;
        if (illegal !== exp_vec) begin
            bad++;
            $display("FAIL illegal_pulse who=%0d code=%0d got=%b exp=%b", who, code, illegal, exp_vec);
        end
        total++;
        if ({p1_ready, p2_ready} !== 2'b11) begin
            bad++;
            $display("FAIL ready_after_illegal got=%b exp=11", {p1_ready, p2_ready});
        end
        step();
        total++;
        if (illegal !== 2'b00) begin
            bad++;
            $display("FAIL illegal_one_cycle got=%b exp=00", illegal);
        end
    endtask

    // mode 0: same cycle, 1: p1 first, 2: p2 first; gap = idle cycles between.
    task automatic play_round(input int a, input int b, input int mode, input int gap);
        logic [1:0] exp_res;
        int n;
        exp_res = (a > b) ? 2'b01 : ((b > a) ? 2'b10 : 2'b00);
        if (mode == 0) begin
            p1_valid = 1'b1; p1_code = 4'(a);
            p2_valid = 1'b1; p2_code = 4'(b);
            step();
            p1_valid = 1'b0; p2_valid = 1'b0;
        end else begin
            if (mode == 1) begin p1_valid = 1'b1; p1_code = 4'(a); end
            else           begin p2_valid = 1'b1; p2_code = 4'(b); end
            step();
            p1_valid = 1'b0; p2_valid = 1'b0;
            total++;
            if ({p1_ready, p2_ready} !== ((mode == 1) ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL ready_half_full mode=%0d got=%b", mode, {p1_ready, p2_ready});
            end
            repeat (gap) step();
            if (mode == 1) begin p2_valid = 1'b1; p2_code = 4'(b); end
            else           begin p1_valid = 1'b1; p1_code = 4'(a); end
            step();
            p1_valid = 1'b0; p2_valid = 1'b0;
        end
        total++;
        if ({p1_ready, p2_ready, result_valid} !== 3'b000) begin
            bad++;
            $display("FAIL judge_cycle ready/result_valid got=%b exp=000", {p1_ready, p2_ready, result_valid});
        end
        m_used1[a] = 1'b1;
        m_used2[b] = 1'b1;
        if (a > b) m_s1++;
        if (b > a) m_s2++;
        m_round++;
        n = 0;
        do begin
            step();
            n++;
        end while (!result_valid && n < 4);
        total++;
        if (n != 1 || !result_valid) begin
            bad++;
            $display("FAIL result_latency got=%0d cycles valid=%b exp=1 cycle", n, result_valid);
        end
        total++;
        if (result !== exp_res) begin
            bad++;
            $display("FAIL result a=%0d b=%0d got=%b exp=%b", a, b, result, exp_res);
        end
        total++;
        if ({p1_score, p2_score, round_cnt} !== {4'(m_s1), 4'(m_s2), 4'(m_round)}) begin
            bad++;
            $display("FAIL score_round got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     p1_score, p2_score, round_cnt, m_s1, m_s2, m_round);
        end
        total++;
        if ({p1_used, p2_used} !== {mask_of(m_used1), mask_of(m_used2)}) begin
            bad++;
            $display("FAIL used got=%h/%h exp=%h/%h", p1_used, p2_used, mask_of(m_used1), mask_of(m_used2));
        end
`ifdef LAST_CARD_OUT_EN
        total++;
        if ({p1_last, p2_last} !== {9'(1 << a), 9'(1 << b)}) begin
            bad++;
            $display("FAIL last got=%h/%h exp=%h/%h", p1_last, p2_last, 9'(1 << a), 9'(1 << b));
        end
`endif
        total++;
        if ({game_over, p1_ready, p2_ready} !== ((m_round == NC) ? 3'b100 : 3'b011)) begin
            bad++;
            $display("FAIL post_round game_over/ready got=%b round=%0d", {game_over, p1_ready, p2_ready}, m_round);
        end
        step();
        total++;
        if (result_valid !== 1'b0) begin
            bad++;
            $display("FAIL result_pulse_width got=%b exp=0", result_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        p1_valid = 1'b1; p1_code = 4'd2;
        step();
        p1_valid = 1'b0;
        total++;
        if (p1_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_pre_slot_full got=%b exp=0", p1_ready);
        end
        #2 resetn = 1'b0;
        #1;
        total++;
        if ({p1_used, p2_used, p1_score, p2_score, round_cnt, result_valid, result, illegal, game_over} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h/%h/%0d/%0d/%0d/%b/%b/%b/%b exp=all zero",
                     p1_used, p2_used, p1_score, p2_score, round_cnt, result_valid, result, illegal, game_over);
        end
        #1 resetn = 1'b1;
        step();
        total++;
        if ({p1_ready, p2_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=11", {p1_ready, p2_ready});
        end
        // Abandoned p1 slot: a lone p2 card must not start a judge.
        p2_valid = 1'b1; p2_code = 4'd5;
        step();
        p2_valid = 1'b0;
        repeat (3) step();
        total++;
        if ({result_valid, round_cnt, p1_ready, p2_ready} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_slot_lost got=%b/%0d/%b%b exp=0/0/10", result_valid, round_cnt, p1_ready, p2_ready);
        end
        do_reset();
    endtask

    task automatic test_normal_round();
        do_reset();
        play_round(7, 3, 1, 1);
        total++;
        if ({result, p1_score, p1_used, p2_used, round_cnt} !== {2'b01, 4'd1, 9'h080, 9'h008, 4'd1}) begin
            bad++;
            $display("FAIL normal_round got=%b/%0d/%h/%h/%0d exp=01/1/080/008/1",
                     result, p1_score, p1_used, p2_used, round_cnt);
        end
`ifdef LAST_CARD_OUT_EN
        total++;
        if ({p1_last, p2_last} !== {9'h080, 9'h008}) begin
            bad++;
            $display("FAIL normal_last got=%h/%h exp=080/008", p1_last, p2_last);
        end
`endif
    endtask

    task automatic test_illegal();
        int who, code, a, b;
        offer_illegal(1, 7);
        offer_illegal(2, 12);
        for (int k = 0; k < 6; k++) begin
            who = int'($urandom_range(1, 2));
            code = int'($urandom_range(NC, 15));
            if ($urandom_range(0, 1) == 1) code = (who == 1) ? 7 : 3;
            offer_illegal(who, code);
        end
        // Nothing latched by the rejects: a clean round still judges correctly.
        do a = int'($urandom_range(0, NC - 1)); while (m_used1[a]);
        do b = int'($urandom_range(0, NC - 1)); while (m_used2[b]);
        play_round(a, b, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    endtask

    task automatic test_tie();
        do_reset();
        play_round(4, 4, 0, 0);
        total++;
        if ({result, p1_score, p2_score, p1_used, p2_used} !== {2'b00, 4'd0, 4'd0, 9'h010, 9'h010}) begin
            bad++;
            $display("FAIL tie got=%b/%0d/%0d/%h/%h exp=00/0/0/010/010",
                     result, p1_score, p2_score, p1_used, p2_used);
        end
    endtask

    task automatic test_full_game();
        int p1c [NC];
        int p2c [NC];
        int j, t, who, code;
        do_reset();
        for (int i = 0; i < NC; i++) begin
            p1c[i] = i;
            p2c[i] = i;
        end
        for (int i = NC - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = p1c[i]; p1c[i] = p1c[j]; p1c[j] = t;
            j = int'($urandom_range(0, i));
            t = p2c[i]; p2c[i] = p2c[j]; p2c[j] = t;
        end
        for (int r = 0; r < NC; r++) begin
            if (r > 0 && $urandom_range(0, 2) == 0) begin
                who = int'($urandom_range(1, 2));
                code = (who == 1) ? p1c[r - 1] : p2c[r - 1];
                if ($urandom_range(0, 1) == 1) code = int'($urandom_range(NC, 15));
                offer_illegal(who, code);
            end
            play_round(p1c[r], p2c[r], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
        total++;
        if ({game_over, p1_used, p2_used, p1_ready, p2_ready, round_cnt} !== {1'b1, 9'h1FF, 9'h1FF, 2'b00, 4'd9}) begin
            bad++;
            $display("FAIL game_end got=%b/%h/%h/%b%b/%0d exp=1/1ff/1ff/00/9",
                     game_over, p1_used, p2_used, p1_ready, p2_ready, round_cnt);
        end
        for (int k = 0; k < 5; k++) begin
            p1_valid = 1'b1; p1_code = 4'($urandom_range(0, 15));
            p2_valid = 1'b1; p2_code = 4'($urandom_range(0, 15));
            step();
            total++;
            if ({result_valid, illegal, p1_score, p2_score, round_cnt, game_over} !==
                {1'b0, 2'b00, 4'(m_s1), 4'(m_s2), 4'd9, 1'b1}) begin
                bad++;
                $display("FAIL done_ignores_valid got=%b/%b/%0d/%0d/%0d/%b exp=0/00/%0d/%0d/9/1",
                         result_valid, illegal, p1_score, p2_score, round_cnt, game_over, m_s1, m_s2);
            end
        end
        p1_valid = 1'b0;
        p2_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_round();
        test_illegal();
        test_tie();
        test_full_game();
        test_full_game();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
